// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit between the MEM stage and a word RAM.
// Big-endian lanes, LWL/LWR/SWL/SWR merging, alignment exceptions.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_wd,
  output logic        req_ready,
  output logic        stall_req,
  output logic        ram_ce,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [3:0]  ram_sel,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ack,
  output logic        wb_valid,
  output logic [4:0]  wb_wd,
  output logic [31:0] wb_wdata,
  output logic        done,
  output logic        exc_adel,
  output logic        exc_ades
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [3:0] OP_LB  = 4'd0;
  localparam logic [3:0] OP_LBU = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LW  = 4'd4;
  localparam logic [3:0] OP_LWL = 4'd5;
  localparam logic [3:0] OP_LWR = 4'd6;
  localparam logic [3:0] OP_SB  = 4'd8;
  localparam logic [3:0] OP_SH  = 4'd9;
  localparam logic [3:0] OP_SW  = 4'd10;
  localparam logic [3:0] OP_SWL = 4'd11;
  localparam logic [3:0] OP_SWR = 4'd12;

  logic [1:0]  state;
  logic [3:0]  op_q;
  logic [1:0]  off_q;
  logic [31:0] rt_q;
  logic [4:0]  wd_q;

  logic        accept;
  logic [1:0]  off;
  logic        d_mem;
  logic        d_we;
  logic [3:0]  d_sel;
  logic [31:0] d_wdata;
  logic        d_adel;
  logic        d_ades;

  logic [7:0]  lbyte;
  logic [15:0] lhalf;
  logic [31:0] ld_data;

  assign req_ready = (state != S_ACCESS);
  assign stall_req = req_valid & ~req_ready;
  assign accept    = req_valid & req_ready;
  assign off       = req_addr[1:0];

  // Decode the incoming op into a RAM command or an exception.
  always_comb begin
    d_mem   = 1'b0;
    d_we    = 1'b0;
    d_sel   = 4'b0000;
    d_wdata = 32'd0;
    d_adel  = 1'b0;
    d_ades  = 1'b0;
    unique case (1'b1)
      (req_op == OP_LB) || (req_op == OP_LBU): begin
        d_mem = 1'b1;
        d_sel = 4'b1111;
      end
      (req_op == OP_LH) || (req_op == OP_LHU): begin
        if (off[0]) begin
          d_adel = 1'b1;
        end else begin
          d_mem = 1'b1;
          d_sel = 4'b1111;
        end
      end
      (req_op == OP_LW): begin
        if (|off) begin
          d_adel = 1'b1;
        end else begin
          d_mem = 1'b1;
          d_sel = 4'b1111;
        end
      end
      (req_op == OP_LWL) || (req_op == OP_LWR): begin
        d_mem = 1'b1;
        d_sel = 4'b1111;
      end
      (req_op == OP_SB): begin
        d_mem   = 1'b1;
        d_we    = 1'b1;
        d_sel   = 4'b0001 << (2'd3 - off);
        d_wdata = {4{req_wdata[7:0]}};
      end
      (req_op == OP_SH): begin
        if (off[0]) begin
          d_ades = 1'b1;
        end else begin
          d_mem   = 1'b1;
          d_we    = 1'b1;
          d_sel   = off[1] ? 4'b0011 : 4'b1100;
          d_wdata = {2{req_wdata[15:0]}};
        end
      end
      (req_op == OP_SW): begin
        if (|off) begin
          d_ades = 1'b1;
        end else begin
          d_mem   = 1'b1;
          d_we    = 1'b1;
          d_sel   = 4'b1111;
          d_wdata = req_wdata;
        end
      end
      (req_op == OP_SWL): begin
        d_mem   = 1'b1;
        d_we    = 1'b1;
        d_sel   = 4'b1111 >> off;
        d_wdata = req_wdata >> {off, 3'b000};
      end
      (req_op == OP_SWR): begin
        d_mem   = 1'b1;
        d_we    = 1'b1;
        d_sel   = 4'b1111 << (2'd3 - off);
        d_wdata = req_wdata << {~off, 3'b000};
      end
      default: begin
        d_mem = 1'b0;
      end
    endcase
  end

  // Pick the addressed byte/halfword lane of the returned word.
  always_comb begin
    lbyte = ram_rdata[31:24];
    unique case (off_q)
      2'd0: lbyte = ram_rdata[31:24];
      2'd1: lbyte = ram_rdata[23:16];
      2'd2: lbyte = ram_rdata[15:8];
      2'd3: lbyte = ram_rdata[7:0];
      default: lbyte = ram_rdata[31:24];
    endcase
    lhalf = off_q[1] ? ram_rdata[15:0] : ram_rdata[31:16];
  end

  // Format load writeback data, merging rt for LWL/LWR.
  always_comb begin
    ld_data = ram_rdata;
    case (op_q)
      OP_LB:  ld_data = {{24{lbyte[7]}}, lbyte};
      OP_LBU: ld_data = {24'd0, lbyte};
      OP_LH:  ld_data = {{16{lhalf[15]}}, lhalf};
      OP_LHU: ld_data = {16'd0, lhalf};
      OP_LWL: begin
        unique case (off_q)
          2'd0: ld_data = ram_rdata;
          2'd1: ld_data = {ram_rdata[23:0], rt_q[7:0]};
          2'd2: ld_data = {ram_rdata[15:0], rt_q[15:0]};
          2'd3: ld_data = {ram_rdata[7:0], rt_q[23:0]};
          default: ld_data = ram_rdata;
        endcase
      end
      OP_LWR: begin
        unique case (off_q)
          2'd0: ld_data = {rt_q[31:8], ram_rdata[31:24]};
          2'd1: ld_data = {rt_q[31:16], ram_rdata[31:16]};
          2'd2: ld_data = {rt_q[31:24], ram_rdata[31:8]};
          2'd3: ld_data = ram_rdata;
          default: ld_data = ram_rdata;
        endcase
      end
      default: ld_data = ram_rdata;
    endcase
  end

  // FSM plus registered RAM command and completion outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      op_q      <= 4'd0;
      off_q     <= 2'd0;
      rt_q      <= 32'd0;
      wd_q      <= 5'd0;
      ram_ce    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= 32'd0;
      ram_sel   <= 4'd0;
      ram_wdata <= 32'd0;
      wb_valid  <= 1'b0;
      wb_wd     <= 5'd0;
      wb_wdata  <= 32'd0;
      done      <= 1'b0;
      exc_adel  <= 1'b0;
      exc_ades  <= 1'b0;
    end else begin
      done     <= 1'b0;
      exc_adel <= 1'b0;
      exc_ades <= 1'b0;
      wb_valid <= 1'b0;
      wb_wd    <= 5'd0;
      wb_wdata <= 32'd0;
      unique case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            op_q  <= req_op;
            off_q <= off;
            rt_q  <= req_wdata;
            wd_q  <= req_wd;
            if (d_mem) begin
              state     <= S_ACCESS;
              ram_ce    <= 1'b1;
              ram_we    <= d_we;
              ram_addr  <= {req_addr[31:2], 2'b00};
              ram_sel   <= d_sel;
              ram_wdata <= d_wdata;
            end else begin
              state    <= S_DONE;
              done     <= 1'b1;
              exc_adel <= d_adel;
              exc_ades <= d_ades;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_ACCESS: begin
          if (ram_ack) begin
            state     <= S_DONE;
            ram_ce    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= 32'd0;
            ram_sel   <= 4'd0;
            ram_wdata <= 32'd0;
            done      <= 1'b1;
            if (!ram_we) begin
              wb_valid <= 1'b1;
              wb_wd    <= wd_q;
              wb_wdata <= ld_data;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
